// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Optional macro BIN2BCD_LEADING_ZERO_BLANK_EN enables the registered leading-zero blank mask.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 12,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   src_q, src_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted;

  // Add-3 correction on every digit >= 5, then shift in the next source bit
  always_comb begin
    adj = work_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
    shifted = (adj << 1) | BCD_W'(src_q[BIN_W-1]);
  end

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] mask;

  // Digit i blanks when it and every higher digit are zero; units never blank
  always_comb begin
    logic upper_zero;
    mask       = '0;
    upper_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (shifted[4*i +: 4] == 4'd0);
      mask[i]    = upper_zero & ~ovf_pend_q;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    blank_d    = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d      = bin;
          work_d     = '0;
          cnt_d      = CNT_W'(BIN_W);
          ovf_pend_d = (32'(bin) > MAX_VAL);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        work_d = shifted;
        src_d  = src_q << 1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = ovf_pend_q ? {DIGITS{4'h9}} : shifted;
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
          blank_d = mask;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      src_q      <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
      blank_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
      blank_q    <= blank_d;
`endif
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign ovf   = ovf_q;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule
